// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel and the decode handshake.
// The master modport is the fetch unit; the slave side is memory plus decode.
interface inst_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output if_valid,
        output if_pc,
        output if_inst,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  if_valid,
        input  if_pc,
        input  if_inst,
        output if_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// LA32R fetch stage: owns the PC, issues credit-limited word fetches and buffers {pc, inst}
// pairs for decode. Handles redirect flushes (dropping in-flight responses) and halt.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h1C00_0000,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] HALT_INST = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_global_en,
    input  logic                  i_redirect_valid,
    input  logic [31:0]           i_redirect_pc,
    inst_fetch_unit_if.master     bus,
    output logic                  o_halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          r_halt;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_inst [DEPTH];

    logic          w_credit_ok;
    logic          w_issue;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;

    // FIFO slots plus in-flight requests never exceed DEPTH, so a push always finds room.
    assign w_credit_ok = ({1'b0, r_outst} + {1'b0, r_count}) < (CW + 1)'(DEPTH);
    assign w_not_empty = (r_count != '0);

    assign bus.imem_req_valid = i_global_en & ~i_redirect_valid & ~r_halt & w_credit_ok;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = i_global_en & ~i_redirect_valid & w_not_empty;
    assign bus.if_pc          = w_not_empty ? r_fifo_pc[r_rd_ptr]   : 32'h0;
    assign bus.if_inst        = w_not_empty ? r_fifo_inst[r_rd_ptr] : 32'h0;
    assign o_halted           = r_halt;

    assign w_issue = bus.imem_req_valid & bus.imem_req_ready;
    assign w_resp  = bus.imem_resp_valid;
    assign w_drop  = (r_discard != '0);
    assign w_push  = w_resp & ~w_drop & ~i_redirect_valid;
    assign w_pop   = bus.if_valid & bus.if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_rsp_pc  <= RESET_PC;
            r_outst   <= '0;
            r_discard <= '0;
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_halt    <= 1'b0;
        end else if (i_redirect_valid) begin
            // outst already includes the responses still owed to discard, so the
            // new drop count is simply everything left in flight after this cycle.
            r_pc      <= i_redirect_pc;
            r_rsp_pc  <= i_redirect_pc;
            r_outst   <= r_outst - CW'(w_resp);
            r_discard <= r_outst - CW'(w_resp);
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_halt    <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
            r_outst <= r_outst + CW'(w_issue) - CW'(w_resp);
            if (w_resp && w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_rsp_pc <= r_rsp_pc + 32'd4;
                if (bus.imem_resp_data == HALT_INST) begin
                    r_halt <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
            r_fifo_inst[r_wr_ptr] <= bus.imem_resp_data;
        end
    end
endmodule
